// File: rtl/pwm_led_pkg.sv
// Shared types and constants for the LED PWM generator.
// The optional start-phase delay is built when PWM_LED_PHASE_EN is defined.
package pwm_led_pkg;

    // Per-channel sequencer states; DELAY is only reachable with PWM_LED_PHASE_EN.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } ch_state_e;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    localparam int DEF_CH_NUM  = 6;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_BURST_W = 16;

endpackage

// File: rtl/pwm_led_gen_if.sv
// Control/status bundle between the trigger register file and the PWM
// generator. Optional macro: PWM_LED_PHASE_EN adds the per-channel phase bus.
interface pwm_led_gen_if import pwm_led_pkg::*; #(
    parameter int CH_NUM  = DEF_CH_NUM,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) ();

    logic [CH_NUM-1:0]         start;
    logic [CH_NUM-1:0]         polar;
    logic [CH_NUM-1:0]         mode;
    logic [CH_NUM*CNT_W-1:0]   period;
    logic [CH_NUM*CNT_W-1:0]   duty;
    logic [CH_NUM*BURST_W-1:0] burst_num;
`ifdef PWM_LED_PHASE_EN
    logic [CH_NUM*CNT_W-1:0]   phase;
`endif
    logic [CH_NUM-1:0]         pwm;
    logic [CH_NUM-1:0]         busy;
    logic [CH_NUM-1:0]         done;

    modport master (
`ifdef PWM_LED_PHASE_EN
        output phase,
`endif
        output start, polar, mode, period, duty, burst_num,
        input  pwm, busy, done
    );

    modport slave (
`ifdef PWM_LED_PHASE_EN
        input  phase,
`endif
        input  start, polar, mode, period, duty, burst_num,
        output pwm, busy, done
    );

endinterface

// File: rtl/pwm_led_ch.sv
// Single LED PWM channel: launch on start rising edge, continuous or
// fixed-count burst output, period/duty shadowed and reloaded at each wrap.
// Optional macro: PWM_LED_PHASE_EN inserts a phase delay before RUN.
//
// state | meaning
// IDLE  | output inactive, waiting for start rising edge
// DELAY | phase delay after launch, output inactive (PWM_LED_PHASE_EN only)
// RUN   | counting periods, output active while cnt < shadow duty
module pwm_led_ch import pwm_led_pkg::*; #(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               polar,
    input  logic               mode,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   duty,
    input  logic [BURST_W-1:0] burst_num,
`ifdef PWM_LED_PHASE_EN
    input  logic [CNT_W-1:0]   phase,
`endif
    output logic               pwm,
    output logic               busy,
    output logic               done
);

    ch_state_e          state_q, state_n;
    logic               start_d;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [CNT_W-1:0]   per_q, per_n;
    logic [CNT_W-1:0]   duty_q, duty_n;
    logic               mode_q, mode_n;
    logic [BURST_W-1:0] burst_q, burst_n;
    logic [BURST_W-1:0] pulse_q, pulse_n;
    logic               done_q, done_n;
    logic               vld_q, vld_n;
`ifdef PWM_LED_PHASE_EN
    logic [CNT_W-1:0]   dly_q, dly_n;
`endif

    logic               launch;
    logic [CNT_W-1:0]   per_eff;
    logic               wrap;
    logic               last;

    assign launch  = start & ~start_d;
    // A zero period would never wrap; run it as a one-cycle period instead.
    assign per_eff = (per_q == '0) ? CNT_W'(1) : per_q;
    assign wrap    = (cnt_q == per_eff - CNT_W'(1));
    // pulse_q + 1 overflows to 0 when saturated, which never equals a non-zero burst_q.
    assign last    = (mode_q == MODE_BURST) && (burst_q != '0) &&
                     ((pulse_q + BURST_W'(1)) == burst_q);

    // Delayed copy of start for rising-edge launch detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d <= 1'b0;
        end else begin
            start_d <= start;
        end
    end

    // State, counters, shadows and the registered active flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            duty_q  <= '0;
            mode_q  <= MODE_CONT;
            burst_q <= '0;
            pulse_q <= '0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
`ifdef PWM_LED_PHASE_EN
            dly_q   <= '0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            per_q   <= per_n;
            duty_q  <= duty_n;
            mode_q  <= mode_n;
            burst_q <= burst_n;
            pulse_q <= pulse_n;
            done_q  <= done_n;
            vld_q   <= vld_n;
`ifdef PWM_LED_PHASE_EN
            dly_q   <= dly_n;
`endif
        end
    end

    // Next-state logic: launch, phase delay, period wrap, burst end and abort.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        per_n   = per_q;
        duty_n  = duty_q;
        mode_n  = mode_q;
        burst_n = burst_q;
        pulse_n = pulse_q;
        done_n  = 1'b0;
        vld_n   = (state_q == RUN) && (cnt_q < duty_q);
`ifdef PWM_LED_PHASE_EN
        dly_n   = dly_q;
`endif

        case (state_q)
            IDLE: begin
                if (launch) begin
`ifdef PWM_LED_PHASE_EN
                    state_n = DELAY;
                    dly_n   = phase;
`else
                    state_n = RUN;
`endif
                    cnt_n   = '0;
                    pulse_n = '0;
                    per_n   = period;
                    duty_n  = duty;
                    mode_n  = mode;
                    burst_n = burst_num;
                end
            end
`ifdef PWM_LED_PHASE_EN
            DELAY: begin
                if (!start) begin
                    state_n = IDLE;
                end else if (dly_q <= CNT_W'(1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    dly_n = dly_q - CNT_W'(1);
                end
            end
`endif
            RUN: begin
                if (!start) begin
                    state_n = IDLE;
                end else if (wrap) begin
                    cnt_n   = '0;
                    pulse_n = (pulse_q == '1) ? pulse_q : pulse_q + BURST_W'(1);
                    // Mode and burst length stay frozen for the whole run.
                    per_n   = period;
                    duty_n  = duty;
                    if (last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    // Polarity is applied after the register so it takes effect immediately.
    assign pwm  = vld_q ^ polar;

endmodule

// File: rtl/pwm_led_gen.sv
// N-channel LED PWM generator: one independent pwm_led_ch per channel,
// packed configuration buses sliced per channel.
// Optional macro: PWM_LED_PHASE_EN adds a per-channel launch phase delay.
module pwm_led_gen import pwm_led_pkg::*; #(
    parameter int CH_NUM  = DEF_CH_NUM,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic         clk,
    input  logic         rst,
    pwm_led_gen_if.slave bus
);

    logic [CH_NUM-1:0] pwm_v;
    logic [CH_NUM-1:0] busy_v;
    logic [CH_NUM-1:0] done_v;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        pwm_led_ch #(
            .CNT_W   (CNT_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .start     (bus.start[i]),
            .polar     (bus.polar[i]),
            .mode      (bus.mode[i]),
            .period    (bus.period[i*CNT_W +: CNT_W]),
            .duty      (bus.duty[i*CNT_W +: CNT_W]),
            .burst_num (bus.burst_num[i*BURST_W +: BURST_W]),
`ifdef PWM_LED_PHASE_EN
            .phase     (bus.phase[i*CNT_W +: CNT_W]),
`endif
            .pwm       (pwm_v[i]),
            .busy      (busy_v[i]),
            .done      (done_v[i])
        );
    end

    assign bus.pwm  = pwm_v;
    assign bus.busy = busy_v;
    assign bus.done = done_v;

endmodule

// File: tb/tb_pwm_led_gen.sv
// Self-checking bench for pwm_led_gen (default build, phase delay disabled).
module tb_pwm_led_gen;

    localparam int CH = 6;
    localparam int CW = 32;
    localparam int BW = 16;

    typedef struct {
        int       ch;
        logic [2:0] val;   // {pwm, busy, done}
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    pwm_led_gen_if #(.CH_NUM(CH), .CNT_W(CW), .BURST_W(BW)) bus ();

    pwm_led_gen #(.CH_NUM(CH), .CNT_W(CW), .BURST_W(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_ch(input int ch, input int per, input int dt, input logic md,
                          input int bn, input logic pol);
        bus.period[ch*CW +: CW]    = CW'(per);
        bus.duty[ch*CW +: CW]      = CW'(dt);
        bus.mode[ch]               = md;
        bus.burst_num[ch*BW +: BW] = BW'(bn);
        bus.polar[ch]              = pol;
    endtask

    // Expected waveform from launch (m=0 is the sample just after the launch edge).
    task automatic push_run(input int ch, input logic pol, input int p, input int d,
                            input int n, input int cycles);
        int   pe;
        logic act, bz, dn;
        pe = (p == 0) ? 1 : p;
        for (int m = 0; m < cycles; m++) begin
            if (m == 0) begin
                act = 1'b0; bz = 1'b1; dn = 1'b0;
            end else if (n == 0 || m < n * pe) begin
                act = (((m - 1) % pe) < d); bz = 1'b1; dn = 1'b0;
            end else if (m == n * pe) begin
                act = (((m - 1) % pe) < d); bz = 1'b0; dn = 1'b1;
            end else begin
                act = 1'b0; bz = 1'b0; dn = 1'b0;
            end
            sb.push_back('{ch, {act ^ pol, bz, dn}});
        end
    endtask

    task automatic stop_ch(input int ch);
        bus.start[ch] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.polar = 6'b101010;
        @(negedge clk);
        n_tests++;
        if (bus.pwm !== 6'b101010) begin
            n_fail++; $display("FAIL reset_pwm got %b exp %b", bus.pwm, 6'b101010);
        end
        n_tests++;
        if (bus.busy !== 6'b0) begin
            n_fail++; $display("FAIL reset_busy got %b exp %b", bus.busy, 6'b0);
        end
        n_tests++;
        if (bus.done !== 6'b0) begin
            n_fail++; $display("FAIL reset_done got %b exp %b", bus.done, 6'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.pwm, bus.busy} !== {6'b101010, 6'b0}) begin
            n_fail++; $display("FAIL idle_after_reset got %b/%b exp 101010/000000", bus.pwm, bus.busy);
        end
        bus.polar = 6'b010101;
        #1;
        n_tests++;
        if (bus.pwm !== 6'b010101) begin
            n_fail++; $display("FAIL polar_comb got %b exp %b", bus.pwm, 6'b010101);
        end
        bus.polar = 6'b0;
        @(negedge clk);
    endtask

    task automatic test_continuous;
        set_ch(0, 10, 3, 1'b0, 0, 1'b0);
        bus.start[0] = 1'b1;
        push_run(0, 1'b0, 10, 3, 0, 35);
        for (int m = 0; m < 35; m++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]} !== e.val) begin
                n_fail++;
                $display("FAIL continuous m=%0d ch%0d {pwm,busy,done} got %b exp %b",
                         m, e.ch, {bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]}, e.val);
            end
        end
        stop_ch(0);
    endtask

    task automatic test_burst;
        set_ch(1, 5, 2, 1'b1, 4, 1'b0);
        bus.start[1] = 1'b1;
        push_run(1, 1'b0, 5, 2, 4, 31);
        for (int m = 0; m < 31; m++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]} !== e.val) begin
                n_fail++;
                $display("FAIL burst m=%0d ch%0d {pwm,busy,done} got %b exp %b",
                         m, e.ch, {bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]}, e.val);
            end
        end
        // Back-to-back: a fresh rising edge relaunches the finished channel.
        bus.start[1] = 1'b0;
        @(negedge clk);
        bus.start[1] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.busy[1] !== 1'b1) begin
            n_fail++; $display("FAIL burst_relaunch busy got %b exp 1", bus.busy[1]);
        end
        stop_ch(1);
    endtask

    task automatic test_shadow;
        set_ch(2, 8, 4, 1'b0, 0, 1'b0);
        bus.start[2] = 1'b1;
        sb.push_back('{2, 3'b010});
        for (int m = 1; m < 26; m++) begin
            logic act;
            act = (m <= 8) ? ((m - 1) < 4) : (((m - 1) % 8) < 6);
            sb.push_back('{2, {act, 1'b1, 1'b0}});
        end
        for (int m = 0; m < 26; m++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]} !== e.val) begin
                n_fail++;
                $display("FAIL shadow m=%0d ch%0d {pwm,busy,done} got %b exp %b",
                         m, e.ch, {bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]}, e.val);
            end
            if (m == 2) bus.duty[2*CW +: CW] = CW'(6);
        end
        stop_ch(2);
    endtask

    task automatic test_boundaries;
        int p_tab[3] = '{7, 7, 0};
        int d_tab[3] = '{0, 7, 1};
        int n_tab[3] = '{0, 0, 3};
        int c_tab[3] = '{20, 25, 8};
        logic pol_tab[3] = '{1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 3; t++) begin
            set_ch(4, p_tab[t], d_tab[t], (n_tab[t] != 0), n_tab[t], pol_tab[t]);
            bus.start[4] = 1'b1;
            push_run(4, pol_tab[t], p_tab[t], d_tab[t], n_tab[t], c_tab[t]);
            for (int m = 0; m < c_tab[t]; m++) begin
                exp_t e;
                @(negedge clk);
                e = sb.pop_front();
                n_tests++;
                if ({bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]} !== e.val) begin
                    n_fail++;
                    $display("FAIL boundary%0d m=%0d ch%0d {pwm,busy,done} got %b exp %b",
                             t, m, e.ch, {bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]}, e.val);
                end
            end
            stop_ch(4);
        end
        bus.polar[4] = 1'b0;
    endtask

    task automatic test_abort_independence;
        set_ch(3, 20, 10, 1'b0, 0, 1'b0);
        set_ch(5, 6, 2, 1'b0, 0, 1'b1);
        bus.start[3] = 1'b1;
        bus.start[5] = 1'b1;
        for (int m = 0; m < 25; m++) begin
            logic a3, b3, a5;
            a3 = (m >= 1 && m <= 6);
            b3 = (m <= 5);
            a5 = (m >= 1) && (((m - 1) % 6) < 2);
            sb.push_back('{3, {a3, b3, 1'b0}});
            sb.push_back('{5, {a5 ^ 1'b1, 1'b1, 1'b0}});
        end
        for (int m = 0; m < 25; m++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                if ({bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]} !== e.val) begin
                    n_fail++;
                    $display("FAIL abort m=%0d ch%0d {pwm,busy,done} got %b exp %b",
                             m, e.ch, {bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]}, e.val);
                end
            end
            if (m == 5) bus.start[3] = 1'b0;
        end
        stop_ch(5);
        bus.polar[5] = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        set_ch(0, 10, 3, 1'b0, 0, 1'b1);
        bus.start[0] = 1'b1;
        push_run(0, 1'b1, 10, 3, 0, 3);
        for (int m = 0; m < 3; m++) begin
            exp_t e;
            @(negedge clk);
            e = sb.pop_front();
            n_tests++;
            if ({bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]} !== e.val) begin
                n_fail++;
                $display("FAIL rst_mid_run m=%0d ch%0d {pwm,busy,done} got %b exp %b",
                         m, e.ch, {bus.pwm[e.ch], bus.busy[e.ch], bus.done[e.ch]}, e.val);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.pwm[0], bus.busy, bus.done} !== {1'b1, 6'b0, 6'b0}) begin
            n_fail++;
            $display("FAIL rst_async pwm0/busy/done got %b/%b/%b exp 1/000000/000000",
                     bus.pwm[0], bus.busy, bus.done);
        end
        bus.start[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({bus.pwm[0], bus.done} !== {1'b1, 6'b0}) begin
                n_fail++;
                $display("FAIL rst_hold c=%0d pwm0/done got %b/%b exp 1/000000", c, bus.pwm[0], bus.done);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.pwm[0], bus.busy, bus.done} !== {1'b1, 6'b0, 6'b0}) begin
            n_fail++;
            $display("FAIL rst_release pwm0/busy/done got %b/%b/%b exp 1/000000/000000",
                     bus.pwm[0], bus.busy, bus.done);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.start     = '0;
        bus.polar     = '0;
        bus.mode      = '0;
        bus.period    = '0;
        bus.duty      = '0;
        bus.burst_num = '0;
`ifdef PWM_LED_PHASE_EN
        bus.phase     = '0;
`endif
        test_reset;
        test_continuous;
        test_burst;
        test_shadow;
        test_boundaries;
        test_abort_independence;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
